// File: rtl/csa_seq_pkg.sv
// Shared types and width helper for the carry-save accumulating sequencer.
package csa_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    function automatic int unsigned accum_width(input int unsigned width, input int unsigned max_ops);
        return width + $clog2(max_ops);
    endfunction

endpackage

// File: rtl/csa_compress_w.sv
// N-bit 3:2 carry-save compressor; the carry output is left unshifted.
module csa_compress_w #(
    parameter int unsigned N = 7
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic [N-1:0] z,
    output logic [N-1:0] s,
    output logic [N-1:0] c
);

    assign s = x ^ y ^ z;
    assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/csa_accum_sequencer.sv
// Streaming multi-operand adder: redundant sum/carry accumulation per beat,
// a single carry-propagate resolve at the end of each burst.
module csa_accum_sequencer
    import csa_seq_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MAX_OPS = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH+$clog2(MAX_OPS)-1:0] out_sum,
    output logic [$clog2(MAX_OPS):0]       out_count,
    output logic                           out_trunc
);

    localparam int unsigned AW = accum_width(WIDTH, MAX_OPS);
    localparam int unsigned CW = $clog2(MAX_OPS) + 1;

    state_t          r_state;
    logic [AW-1:0]   r_s;
    logic [AW-1:0]   r_c;
    logic [CW-1:0]   r_count;
    logic            r_trunc;
    logic [AW-1:0]   r_out_sum;
    logic [CW-1:0]   r_out_count;
    logic            r_out_trunc;
    logic            r_out_valid;

    logic            w_beat;
    logic [AW-1:0]   w_zext;
    logic [AW-1:0]   w_cs_s;
    logic [AW-1:0]   w_cs_c;
    logic [CW-1:0]   w_count_nxt;

    assign in_ready    = (r_state == IDLE) || (r_state == ACCUM);
    assign w_beat      = in_valid && in_ready;
    assign w_zext      = AW'(in_data);
    assign w_count_nxt = r_count + CW'(1);

    csa_compress_w #(.N(AW)) u_compress (
        .x (r_s),
        .y (r_c),
        .z (w_zext),
        .s (w_cs_s),
        .c (w_cs_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_s         <= '0;
            r_c         <= '0;
            r_count     <= '0;
            r_trunc     <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_trunc <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_beat) begin
                        r_s     <= w_zext;
                        r_c     <= '0;
                        r_count <= CW'(1);
                        r_trunc <= 1'b0;
                        r_state <= in_last ? RESOLVE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (w_beat) begin
                        // Total never reaches 2^AW, so the dropped carry MSB is always zero.
                        r_s     <= w_cs_s;
                        r_c     <= w_cs_c << 1;
                        r_count <= w_count_nxt;
                        if (in_last) begin
                            r_trunc <= 1'b0;
                            r_state <= RESOLVE;
                        end else if (w_count_nxt == CW'(MAX_OPS)) begin
                            r_trunc <= 1'b1;
                            r_state <= RESOLVE;
                        end
                    end
                end
                RESOLVE: begin
                    r_out_sum   <= r_s + r_c;
                    r_out_count <= r_count;
                    r_out_trunc <= r_trunc;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_s         <= '0;
                        r_c         <= '0;
                        r_count     <= '0;
                        r_trunc     <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_count = r_out_count;
    assign out_trunc = r_out_trunc;

endmodule

// File: tb/tb_csa_accum_sequencer.sv
// Self-checking bench: directed and randomized bursts against an arithmetic reference.
module tb_csa_accum_sequencer;

    localparam int unsigned WIDTH   = 4;
    localparam int unsigned MAX_OPS = 8;
    localparam int unsigned AW      = WIDTH + $clog2(MAX_OPS);
    localparam int unsigned CW      = $clog2(MAX_OPS) + 1;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [AW-1:0]     out_sum;
    logic [CW-1:0]     out_count;
    logic              out_trunc;

    int n_checks = 0;
    int n_errors = 0;

    csa_accum_sequencer #(.WIDTH(WIDTH), .MAX_OPS(MAX_OPS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_trunc (out_trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one beat (after an optional idle gap) and hold it until accepted.
    task automatic send(input int unsigned d, input logic last, input int unsigned gap);
        logic acc;
        int   t;
        acc = 1'b0;
        t   = 0;
        for (int g = 0; g < int'(gap); g++) tick();
        in_valid = 1'b1;
        in_data  = WIDTH'(d);
        in_last  = last;
        while (!acc && t < 40) begin
            acc = in_ready;
            tick();
            t++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("beat_accept", 32'(acc), 32'd1);
    endtask

    // Drive a whole burst and check the result against plain arithmetic.
    task automatic run_burst(input int unsigned ops[$], input bit use_last,
                             input bit rand_gaps, input int unsigned hold);
        int unsigned exp_sum;
        int unsigned exp_cnt;
        int unsigned exp_tr;
        exp_sum = 0;
        foreach (ops[i]) exp_sum += ops[i];
        exp_cnt = ops.size();
        exp_tr  = (!use_last && ops.size() == MAX_OPS) ? 1 : 0;
        foreach (ops[i])
            send(ops[i], use_last && (i == ops.size() - 1),
                 rand_gaps ? $urandom_range(0, 2) : 0);
        // One edge after the last accept: resolving, no result yet, input closed.
        check("valid_lat_low", 32'(out_valid), 32'd0);
        check("ready_resolve", 32'(in_ready), 32'd0);
        tick();
        check("valid_lat_high", 32'(out_valid), 32'd1);
        check("sum", 32'(out_sum), exp_sum);
        check("count", 32'(out_count), exp_cnt);
        check("trunc", 32'(out_trunc), exp_tr);
        for (int h = 0; h < int'(hold); h++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'($urandom_range(0, 15));
            check("ready_done", 32'(in_ready), 32'd0);
            tick();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_sum", 32'(out_sum), exp_sum);
            check("hold_count", 32'(out_count), exp_cnt);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_hs_valid", 32'(out_valid), 32'd0);
        check("post_hs_ready", 32'(in_ready), 32'd1);
        check("post_hs_sum", 32'(out_sum), exp_sum);
    endtask

    initial begin
        int unsigned q[$];
        int unsigned n;
        bit          ul;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_sum", 32'(out_sum), 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        check("rst_trunc", 32'(out_trunc), 32'd0);
        rst = 1'b0;
        tick();

        q = '{4, 5, 5};               run_burst(q, 1'b1, 1'b0, 0);
        q = '{8, 8, 8};               run_burst(q, 1'b1, 1'b0, 0);
        q = '{10, 8, 2};              run_burst(q, 1'b1, 1'b0, 0);
        q = '{15, 15, 15, 15, 15, 15, 15, 15};
        run_burst(q, 1'b0, 1'b0, 0);
        run_burst(q, 1'b1, 1'b0, 0);
        q = '{7};                     run_burst(q, 1'b1, 1'b0, 0);
        q = '{11, 14, 3};             run_burst(q, 1'b1, 1'b0, 5);

        // Reset mid-burst discards the partial sum.
        send(4, 1'b0, 0);
        send(9, 1'b0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        check("midrst_sum", 32'(out_sum), 32'd0);
        check("midrst_count", 32'(out_count), 32'd0);
        check("midrst_trunc", 32'(out_trunc), 32'd0);
        q = '{4, 9, 4};               run_burst(q, 1'b1, 1'b0, 0);
        run_burst(q, 1'b1, 1'b1, 0);

        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(1, MAX_OPS);
            ul = (n == MAX_OPS) ? 1'($urandom_range(0, 1)) : 1'b1;
            q = {};
            for (int i = 0; i < int'(n); i++) q.push_back($urandom_range(0, 15));
            run_burst(q, ul, 1'b1, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
